mem_issue_unit: RTL

Downstream stage of the load/store queue: takes the queue's head entry, issues it to the data cache once legal, waits for the cache response and pulses the queue dequeue. Loads are aligned, sign- or zero-extended per funct3 and broadcast on the CDB. Stores are reported to the ROB as done. A ROB flush with a request in flight drains the response without retiring anything.

---
 rtl/mem_issue_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_issue_unit.sv
// Memory issue stage: issues the LSQ head entry to the data cache, waits for the
// response, then dequeues it and either broadcasts the load result or reports the store as done.
module mem_issue_unit #(
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned PD_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 head_valid,
    input  logic                 head_addr_valid,
    input  logic                 head_is_store,
    input  logic [31:0]          head_addr,
    input  logic [3:0]           head_rmask,
    input  logic [3:0]           head_wmask,
    input  logic [31:0]          head_wdata,
    input  logic [2:0]           head_funct3,
    input  logic [ROB_IDX_W-1:0] head_rob_idx,
    input  logic [4:0]           head_rd,
    input  logic [PD_W-1:0]      head_pd,
    input  logic [ROB_IDX_W-1:0] rob_head_idx,
    input  logic                 rob_flush,
    output logic                 lsq_dequeue,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_resp,
    input  logic [31:0]          dmem_rdata,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [4:0]           cdb_rd,
    output logic [PD_W-1:0]      cdb_pd,
    output logic [31:0]          cdb_data,
    output logic                 store_done,
    output logic [ROB_IDX_W-1:0] store_done_rob_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e               state_q, state_d;

    logic [1:0]           op_lane_q, op_lane_d;
    logic [2:0]           op_funct3_q, op_funct3_d;
    logic [ROB_IDX_W-1:0] op_rob_idx_q, op_rob_idx_d;
    logic [4:0]           op_rd_q, op_rd_d;
    logic [PD_W-1:0]      op_pd_q, op_pd_d;
    logic                 op_is_store_q, op_is_store_d;

    logic [31:0]          dmem_addr_q, dmem_addr_d;
    logic [3:0]           dmem_rmask_q, dmem_rmask_d;
    logic [3:0]           dmem_wmask_q, dmem_wmask_d;
    logic [31:0]          dmem_wdata_q, dmem_wdata_d;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
    logic [4:0]           cdb_rd_q, cdb_rd_d;
    logic [PD_W-1:0]      cdb_pd_q, cdb_pd_d;
    logic [31:0]          cdb_data_q, cdb_data_d;
    logic                 store_done_q, store_done_d;
    logic [ROB_IDX_W-1:0] store_done_rob_idx_q, store_done_rob_idx_d;

    logic                 go;

    // Align the response word to the access lane and extend per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [31:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_extract = {24'h000000, sh[7:0]};
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_extract = {16'h0000, sh[15:0]};
            3'b010:  load_extract = sh;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    // Stores wait for the ROB head; loads go as soon as the address is known.
    assign go = head_valid & head_addr_valid & ~rob_flush &
                (~head_is_store | (head_rob_idx == rob_head_idx));

    always_comb begin
        state_d              = state_q;
        op_lane_d            = op_lane_q;
        op_funct3_d          = op_funct3_q;
        op_rob_idx_d         = op_rob_idx_q;
        op_rd_d              = op_rd_q;
        op_pd_d              = op_pd_q;
        op_is_store_d        = op_is_store_q;
        dmem_addr_d          = 32'h0000_0000;
        dmem_rmask_d         = 4'h0;
        dmem_wmask_d         = 4'h0;
        dmem_wdata_d         = 32'h0000_0000;
        cdb_valid_d          = 1'b0;
        cdb_rob_idx_d        = cdb_rob_idx_q;
        cdb_rd_d             = cdb_rd_q;
        cdb_pd_d             = cdb_pd_q;
        cdb_data_d           = cdb_data_q;
        store_done_d         = 1'b0;
        store_done_rob_idx_d = store_done_rob_idx_q;
        lsq_dequeue          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d       = S_REQ;
                    op_lane_d     = head_addr[1:0];
                    op_funct3_d   = head_funct3;
                    op_rob_idx_d  = head_rob_idx;
                    op_rd_d       = head_rd;
                    op_pd_d       = head_pd;
                    op_is_store_d = head_is_store;
                    dmem_addr_d   = {head_addr[31:2], 2'b00};
                    dmem_rmask_d  = head_is_store ? 4'h0 : head_rmask;
                    dmem_wmask_d  = head_is_store ? head_wmask : 4'h0;
                    dmem_wdata_d  = head_is_store ? head_wdata : 32'h0000_0000;
                end
            end
            S_REQ: begin
                state_d = rob_flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (dmem_resp) begin
                    state_d = S_IDLE;
                    if (!rob_flush) begin
                        lsq_dequeue = 1'b1;
                        if (op_is_store_q) begin
                            store_done_d         = 1'b1;
                            store_done_rob_idx_d = op_rob_idx_q;
                        end else begin
                            cdb_valid_d   = 1'b1;
                            cdb_rob_idx_d = op_rob_idx_q;
                            cdb_rd_d      = op_rd_q;
                            cdb_pd_d      = op_pd_q;
                            cdb_data_d    = load_extract(dmem_rdata, op_lane_q, op_funct3_q);
                        end
                    end
                end else if (rob_flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dmem_resp) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q              <= S_IDLE;
            op_lane_q            <= 2'b00;
            op_funct3_q          <= 3'b000;
            op_rob_idx_q         <= '0;
            op_rd_q              <= 5'd0;
            op_pd_q              <= '0;
            op_is_store_q        <= 1'b0;
            dmem_addr_q          <= 32'h0000_0000;
            dmem_rmask_q         <= 4'h0;
            dmem_wmask_q         <= 4'h0;
            dmem_wdata_q         <= 32'h0000_0000;
            cdb_valid_q          <= 1'b0;
            cdb_rob_idx_q        <= '0;
            cdb_rd_q             <= 5'd0;
            cdb_pd_q             <= '0;
            cdb_data_q           <= 32'h0000_0000;
            store_done_q         <= 1'b0;
            store_done_rob_idx_q <= '0;
        end else begin
            state_q              <= state_d;
            op_lane_q            <= op_lane_d;
            op_funct3_q          <= op_funct3_d;
            op_rob_idx_q         <= op_rob_idx_d;
            op_rd_q              <= op_rd_d;
            op_pd_q              <= op_pd_d;
            op_is_store_q        <= op_is_store_d;
            dmem_addr_q          <= dmem_addr_d;
            dmem_rmask_q         <= dmem_rmask_d;
            dmem_wmask_q         <= dmem_wmask_d;
            dmem_wdata_q         <= dmem_wdata_d;
            cdb_valid_q          <= cdb_valid_d;
            cdb_rob_idx_q        <= cdb_rob_idx_d;
            cdb_rd_q             <= cdb_rd_d;
            cdb_pd_q             <= cdb_pd_d;
            cdb_data_q           <= cdb_data_d;
            store_done_q         <= store_done_d;
            store_done_rob_idx_q <= store_done_rob_idx_d;
        end
    end

    // A flush arriving while a result is being presented kills it.
    assign cdb_valid          = cdb_valid_q & ~rob_flush;
    assign store_done         = store_done_q & ~rob_flush;
    assign cdb_rob_idx        = cdb_rob_idx_q;
    assign cdb_rd             = cdb_rd_q;
    assign cdb_pd             = cdb_pd_q;
    assign cdb_data           = cdb_data_q;
    assign store_done_rob_idx = store_done_rob_idx_q;
    assign dmem_addr          = dmem_addr_q;
    assign dmem_rmask         = dmem_rmask_q;
    assign dmem_wmask         = dmem_wmask_q;
    assign dmem_wdata         = dmem_wdata_q;

endmodule
